// File: rtl/demux1x8_buf.sv
// Registered 1-to-8 demultiplexer with per-slot hold-until-acknowledged output slots.
// Optional broadcast (all slots load I at once) is enabled by defining DEMUX1X8_BCAST_EN.
module demux1x8_buf #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   I,
    input  logic [2:0]         S,
    input  logic               in_valid,
`ifdef DEMUX1X8_BCAST_EN
    input  logic               bcast,
`endif
    output logic               in_ready,
    output logic [8*WIDTH-1:0] Q,
    output logic [7:0]         V,
    input  logic [7:0]         A,
    output logic [3:0]         occ,
    output logic               all_full
);

    logic [7:0]            v_q, v_d;
    logic [7:0][WIDTH-1:0] q_q, q_d;
    logic [3:0]            occ_q, occ_d;
    logic                  full_q, full_d;
    logic [7:0]            wr, cons;
    logic [3:0]            inc, dec;
    logic                  rdy, bc_req;

`ifdef DEMUX1X8_BCAST_EN
    assign bc_req = in_valid & bcast;
`else
    assign bc_req = 1'b0;
`endif

    always_comb begin
        rdy = bc_req ? &(~v_q | A) : (~v_q[S] | A[S]);
        wr  = '0;
        if (in_valid && rdy)
            wr = bc_req ? 8'hFF : (8'h01 << S);
        // A slot rewritten this cycle stays held even if it is also acknowledged.
        cons = v_q & A & ~wr;
        v_d  = (v_q & ~cons) | wr;
        q_d  = q_q;
        inc  = '0;
        dec  = '0;
        for (int k = 0; k < 8; k++) begin
            if (wr[k])
                q_d[k] = I;
            inc = inc + {3'b000, wr[k] & ~v_q[k]};
            dec = dec + {3'b000, cons[k]};
        end
        occ_d  = occ_q + inc - dec;
        full_d = (occ_d == 4'd8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            q_q    <= '0;
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            q_q    <= q_d;
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

    assign in_ready = rdy;
    assign Q        = q_q;
    assign V        = v_q;
    assign occ      = occ_q;
    assign all_full = full_q;

endmodule

// File: tb/tb_demux1x8_buf.sv
// Self-checking bench for demux1x8_buf: directed vector table, hand sequences and
// randomized traffic against a slot-array reference model.
module tb_demux1x8_buf;

`ifdef DEMUX1X8_BCAST_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, all_full, bcast;
    logic [3:0]  I, occ;
    logic [2:0]  S;
    logic [31:0] Q;
    logic [7:0]  V, A;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] mv = '0;
    logic [3:0] mq [8];
    int         mocc = 0;
    logic       rdy_seen;

    always #5 clk = ~clk;

    demux1x8_buf #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .I(I), .S(S), .in_valid(in_valid),
`ifdef DEMUX1X8_BCAST_EN
        .bcast(bcast),
`endif
        .in_ready(in_ready), .Q(Q), .V(V), .A(A), .occ(occ), .all_full(all_full)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_q();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[k*4 +: 4] = mq[k];
        return r;
    endfunction

    // Apply one cycle of inputs, check in_ready before the edge, outputs after it.
    task automatic drive(input logic r, input logic [3:0] i, input logic [2:0] s,
                         input logic iv, input logic [7:0] a, input logic bc);
        logic is_bc, exp_rdy, acc;
        reset = r; I = i; S = s; in_valid = iv; A = a; bcast = bc;
        is_bc = BC_EN && iv && bc;
        exp_rdy = 1'b1;
        if (is_bc) begin
            for (int k = 0; k < 8; k++)
                if (mv[k] && !a[k]) exp_rdy = 1'b0;
        end else
            exp_rdy = !mv[s] || a[s];
        #1;
        rdy_seen = in_ready;
        if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        acc = !r && iv && exp_rdy;
        for (int k = 0; k < 8; k++) begin
            if (r) begin
                mv[k] = 1'b0; mq[k] = 4'h0;
            end else if (acc && (is_bc || s == 3'(k))) begin
                mv[k] = 1'b1; mq[k] = i;
            end else if (a[k])
                mv[k] = 1'b0;
        end
        mocc = 0;
        for (int k = 0; k < 8; k++) mocc += int'(mv[k]);
        #1;
        chk("V", {24'd0, V}, {24'd0, mv});
        chk("Q", Q, model_q());
        chk("occ", {28'd0, occ}, 32'(mocc));
        chk("all_full", {31'd0, all_full}, {31'd0, (mocc == 8)});
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] i;
        logic [2:0] s;
        logic       iv;
        logic [7:0] a;
        logic       rdy;
        logic [7:0] v;
        logic [3:0] occ;
        logic       full;
        int         slot;
        logic [3:0] slot_val;
    } vec_t;

    vec_t tbl[$];

    initial begin
        for (int k = 0; k < 8; k++) mq[k] = 4'h0;
        reset = 1'b1; I = '0; S = '0; in_valid = 1'b0; A = '0; bcast = 1'b0;

        // rst, I, S, iv, A, rdy, V, occ, full, slot, slot value
        tbl.push_back('{1, 4'h0, 3'd0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 0, 4'h0});
        tbl.push_back('{1, 4'h0, 3'd0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 7, 4'h0});
        tbl.push_back('{0, 4'hA, 3'd3, 1, 8'h00, 1, 8'h08, 4'd1, 0, 3, 4'hA});
        tbl.push_back('{0, 4'h0, 3'd3, 0, 8'h08, 1, 8'h00, 4'd0, 0, 3, 4'hA});
        for (int k = 0; k < 8; k++)
            tbl.push_back('{0, 4'(k + 1), 3'(k), 1, 8'h00, 1, 8'((16'h1 << (k + 1)) - 1),
                            4'(k + 1), (k == 7), k, 4'(k + 1)});
        tbl.push_back('{0, 4'h9, 3'd5, 1, 8'h00, 0, 8'hFF, 4'd8, 1, 5, 4'h6});
        tbl.push_back('{0, 4'h0, 3'd2, 0, 8'h04, 1, 8'hFB, 4'd7, 0, 2, 4'h3});
        tbl.push_back('{0, 4'h1, 3'd2, 1, 8'h00, 1, 8'hFF, 4'd8, 1, 2, 4'h1});
        tbl.push_back('{0, 4'h7, 3'd2, 1, 8'h04, 1, 8'hFF, 4'd8, 1, 2, 4'h7});
        tbl.push_back('{0, 4'h0, 3'd0, 0, 8'hC3, 1, 8'h3C, 4'd4, 0, 0, 4'h1});
        tbl.push_back('{1, 4'hE, 3'd0, 1, 8'h04, 1, 8'h00, 4'd0, 0, 0, 4'h0});

        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].i, tbl[n].s, tbl[n].iv, tbl[n].a, 1'b0);
            if (!tbl[n].rst) chk("vec_rdy", {31'd0, rdy_seen}, {31'd0, tbl[n].rdy});
            chk("vec_V", {24'd0, V}, {24'd0, tbl[n].v});
            chk("vec_occ", {28'd0, occ}, {28'd0, tbl[n].occ});
            chk("vec_full", {31'd0, all_full}, {31'd0, tbl[n].full});
            chk("vec_slot", {28'd0, Q[tbl[n].slot*4 +: 4]}, {28'd0, tbl[n].slot_val});
        end

        // idle after reset: every select is ready
        for (int s = 0; s < 8; s++) begin
            S = 3'(s); in_valid = 1'b1; A = '0; reset = 1'b0; #1;
            chk("idle_rdy", {31'd0, in_ready}, 32'd1);
        end

        if (BC_EN) begin
            drive(1, 4'h0, 3'd0, 0, 8'h00, 0);
            drive(0, 4'h2, 3'd0, 1, 8'h00, 0);
            drive(0, 4'hF, 3'd6, 1, 8'h01, 1);
            chk("bc_rdy", {31'd0, rdy_seen}, 32'd1);
            chk("bc_V", {24'd0, V}, 32'hFF);
            chk("bc_Q", Q, 32'hFFFF_FFFF);
            chk("bc_occ", {28'd0, occ}, 32'd8);
            drive(0, 4'h3, 3'd1, 1, 8'h00, 1);
            chk("bc_block", {31'd0, rdy_seen}, 32'd0);
            chk("bc_hold", Q, 32'hFFFF_FFFF);
        end

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            a = 8'($urandom) & 8'($urandom) & 8'($urandom);
            drive(($urandom_range(0, 49) == 0), 4'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) != 0), a, ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux1x8_buf.md
Name: demux1x8_buf

Overview:
- Registered 1-to-8 demultiplexer: the distribution counterpart of the team's 8:1 select muxes.
- Accepts one WIDTH-bit word with a 3-bit destination select under a valid/ready handshake.
- Holds the word in that destination's output slot until the consumer acknowledges it.
- Sits between a single producer and eight independent consumers, e.g. feeding eight 4-bit lanes that are later recombined by an 8:1 mux.

Parameters:
- WIDTH, 4, data width of each word and of each output slot.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- I  input  WIDTH  input data word.
- S  input  3  destination select; slot index 0..7.
- in_valid  input  1  producer presents I/S this cycle.
- in_ready  output  1  block can accept the word addressed by S this cycle.
- Q  output  8*WIDTH  slot data, flattened; slot k occupies Q[k*WIDTH +: WIDTH].
- V  output  8  per-slot valid; V[k]=1 means slot k holds an unconsumed word.
- A  input  8  per-slot acknowledge from consumer k; effective only when V[k]=1.
- occ  output  4  number of occupied slots, 0..8.
- all_full  output  1  high when occ==8.

Behaviour:
- Reset (reset=1 at a clk edge): V=0, Q=0, occ=0, all_full=0. Takes priority over every other event; any word or ack in that cycle is discarded.
- in_ready is combinational from S, V and A: in_ready = ~V[S] | A[S]. It never depends on in_valid.
- Accept: a word is accepted when in_valid & in_ready at a rising edge. Then Q slot S <= I and V[S] <= 1.
- Latency: one cycle. The word is visible on Q with V set in the cycle after acceptance.
- Consume: for slot k, when V[k] & A[k] at an edge and slot k is not written that cycle, V[k] <= 0.
  - Q slot k retains its last value after consume; it is not cleared.
  - A[k] while V[k]=0 is ignored.
- Simultaneous consume and write to the same slot: V[k] stays 1 and Q slot k takes the new I. This is back-to-back throughput of one word per cycle per slot.
- Simultaneous events on different slots are independent; any number of acks plus one write may occur in one cycle.
- Full slot: V[S]=1 with A[S]=0 gives in_ready=0. The word is not accepted and the producer must hold it. No other slot is affected; changing S to an empty slot makes in_ready=1 in the same cycle.
- in_valid=0: no write, regardless of S; acks still processed.
- occ is registered. occ_next = occ + (accept writes an empty slot ? 1 : 0) - (number of consumed slots not rewritten).
  - occ never wraps: it is bounded 0..8 by construction.
  - all_full is registered, equal to (occ_next==8).
  - occ always equals popcount(V); verification checks this invariant every cycle.
- No state machine beyond the per-slot valid bits; slot state per k is EMPTY (V=0) or HELD (V=1).
  - EMPTY->HELD on write.
  - HELD->EMPTY on ack without write.
  - HELD->HELD on write+ack or on no ack.

Optional Feature:
- Macro: DEMUX1X8_BCAST_EN.
- When defined, the block adds input port bcast (1 bit).
  - A broadcast is requested when in_valid & bcast; S is ignored.
  - in_ready for a broadcast = &(~V | A), i.e. every slot is empty or being consumed this cycle.
  - On acceptance, all eight slots load I, V <= 8'hFF, occ <= 8, all_full <= 1.
  - bcast=0 behaves exactly as the base block.
- When not defined, the bcast port does not exist and behaviour is the base block only.

Test Plan:
- Reset then idle: assert reset 2 cycles -> V=8'h00, Q=0, occ=0, all_full=0, in_ready=1 for every S.
- Single route: I=4'hA, S=3, in_valid=1 one cycle -> next cycle V=8'h08, Q slot3=4'hA, occ=1. Then A[3]=1 -> V=8'h00, Q slot3 still 4'hA, occ=0.
- Fill all: write I=k+1 to S=k for k=0..7 on consecutive cycles, no acks -> V=8'hFF, slot k = k+1, occ=8, all_full=1. Then in_valid with S=5, A=0 -> in_ready=0 and slot5 unchanged.
- Back-to-back same slot: slot2 held 4'h1; same cycle A[2]=1, I=4'h7, S=2, in_valid=1 -> in_ready=1, next cycle V[2]=1, slot2=4'h7, occ unchanged.
- Reset mid-operation: V=8'h3C, occ=4; assert reset while in_valid=1, S=0, A=8'h04 -> next cycle V=0, Q=0, occ=0, no write to slot0.
- (DEMUX1X8_BCAST_EN) V=8'h01, A=8'h01, bcast=1, I=4'hF, in_valid=1 -> in_ready=1, next cycle V=8'hFF, all slots 4'hF, occ=8. Repeat with A=0 -> in_ready=0.
